// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline stage contents and memory handshake
// in, pipeline write/flush/hold controls and status out.
//   master : pipeline side (drives stage contents, receives controls)
//   slave  : pipe_hazard_ctrl
// Inputs : i_IDEX_MemRead, i_IDEX_Rt, i_IFID_Rs, i_IFID_Rt, i_IFID_Uses_Rt,
//          i_EXMEM_Branch, i_EXMEM_Zero, i_Mem_Req, i_Mem_Ready
// Outputs: o_PC_Write, o_IFID_Write, o_IFID_Flush, o_IDEX_Flush,
//          o_EXMEM_Flush, o_Pipe_Hold, o_Mem_Timeout, o_Stall_Count, o_State
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic             i_IDEX_MemRead;
  logic [REG_W-1:0] i_IDEX_Rt;
  logic [REG_W-1:0] i_IFID_Rs;
  logic [REG_W-1:0] i_IFID_Rt;
  logic             i_IFID_Uses_Rt;
  logic             i_EXMEM_Branch;
  logic             i_EXMEM_Zero;
  logic             i_Mem_Req;
  logic             i_Mem_Ready;
  logic             o_PC_Write;
  logic             o_IFID_Write;
  logic             o_IFID_Flush;
  logic             o_IDEX_Flush;
  logic             o_EXMEM_Flush;
  logic             o_Pipe_Hold;
  logic             o_Mem_Timeout;
  logic [CNT_W-1:0] o_Stall_Count;
  logic [1:0]       o_State;

  modport master (
    output i_IDEX_MemRead, i_IDEX_Rt, i_IFID_Rs, i_IFID_Rt, i_IFID_Uses_Rt,
           i_EXMEM_Branch, i_EXMEM_Zero, i_Mem_Req, i_Mem_Ready,
    input  o_PC_Write, o_IFID_Write, o_IFID_Flush, o_IDEX_Flush,
           o_EXMEM_Flush, o_Pipe_Hold, o_Mem_Timeout, o_Stall_Count, o_State
  );

  modport slave (
    input  i_IDEX_MemRead, i_IDEX_Rt, i_IFID_Rs, i_IFID_Rt, i_IFID_Uses_Rt,
           i_EXMEM_Branch, i_EXMEM_Zero, i_Mem_Req, i_Mem_Ready,
    output o_PC_Write, o_IFID_Write, o_IFID_Flush, o_IDEX_Flush,
           o_EXMEM_Flush, o_Pipe_Hold, o_Mem_Timeout, o_Stall_Count, o_State
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/sequencing controller for the 16-bit, 8-register pipelined
// MIPS core. Resolves load-use stalls, taken-branch flushes and multi-cycle
// data-memory waits, and counts stalled cycles.
// Ports:
//   clk   : controller state updates on the rising edge; the pipeline
//           registers capture on the falling edge, so the control outputs
//           are combinational from state and inputs.
//   reset : asynchronous, active-high; forces all flushes high, enables low.
//   hz    : pipe_hazard_ctrl_if slave (stage contents in, controls out).
module pipe_hazard_ctrl #(
  parameter int REG_W    = 3,
  parameter int WAIT_MAX = 15,  // 1..255
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam logic [7:0]       WAIT_LIMIT = 8'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [7:0]       wait_cnt_r;
  logic [7:0]       wait_cnt_nxt_s;
  logic             tmo_r;
  logic             tmo_set_s;
  logic [CNT_W-1:0] stall_cnt_r;

  logic [REG_W-1:0] idex_rt_s;
  logic [REG_W-1:0] ifid_rs_s;
  logic [REG_W-1:0] ifid_rt_s;
  logic             mem_wait_s;
  logic             taken_s;
  logic             loaduse_s;

  logic pc_write_s;
  logic ifid_write_s;
  logic ifid_flush_s;
  logic idex_flush_s;
  logic exmem_flush_s;
  logic pipe_hold_s;

  assign idex_rt_s = hz.i_IDEX_Rt;
  assign ifid_rs_s = hz.i_IFID_Rs;
  assign ifid_rt_s = hz.i_IFID_Rt;

  // Raw hazard events; register 0 is hard-wired so it never creates a load-use.
  always_comb begin
    mem_wait_s = hz.i_Mem_Req & ~hz.i_Mem_Ready;
    taken_s    = hz.i_EXMEM_Branch & hz.i_EXMEM_Zero;
    loaduse_s  = hz.i_IDEX_MemRead & (idex_rt_s != {REG_W{1'b0}}) &
                 ((idex_rt_s == ifid_rs_s) |
                  (hz.i_IFID_Uses_Rt & (idex_rt_s == ifid_rt_s)));
  end

  // Next-state, wait-counter and control-output decode.
  always_comb begin
    state_nxt_s    = RUN;
    wait_cnt_nxt_s = 8'd0;
    tmo_set_s      = 1'b0;
    pc_write_s     = 1'b1;
    ifid_write_s   = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_flush_s   = 1'b0;
    exmem_flush_s  = 1'b0;
    pipe_hold_s    = 1'b0;
    case (state_r)
      RUN, LU_STALL, FLUSH: begin
        // LU_STALL masks load-use (the stalled pair already got its bubble);
        // FLUSH masks branches (EX/MEM holds a flushed, invalid instruction).
        if (mem_wait_s) begin
          pc_write_s     = 1'b0;
          ifid_write_s   = 1'b0;
          pipe_hold_s    = 1'b1;
          state_nxt_s    = MEM_WAIT;
          wait_cnt_nxt_s = 8'd1;
        end else if (taken_s && (state_r != FLUSH)) begin
          ifid_flush_s  = 1'b1;
          idex_flush_s  = 1'b1;
          exmem_flush_s = 1'b1;
          state_nxt_s   = FLUSH;
        end else if (loaduse_s && (state_r == RUN)) begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          idex_flush_s = 1'b1;
          state_nxt_s  = LU_STALL;
        end else begin
          state_nxt_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (hz.i_Mem_Ready) begin
          // Access completes this cycle: release the hold immediately.
          state_nxt_s = RUN;
        end else if ((wait_cnt_r + 8'd1) >= WAIT_LIMIT) begin
          // This is the WAIT_MAX-th held cycle; give up after it.
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          pipe_hold_s  = 1'b1;
          tmo_set_s    = 1'b1;
          state_nxt_s  = RUN;
        end else begin
          pc_write_s     = 1'b0;
          ifid_write_s   = 1'b0;
          pipe_hold_s    = 1'b1;
          state_nxt_s    = MEM_WAIT;
          wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // FSM state and memory-wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= RUN;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Sticky timeout flag and saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_r       <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      tmo_r <= tmo_r | tmo_set_s;
      if (!pc_write_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  // Output drive; reset overrides the decode so the whole pipe is flushed.
  always_comb begin
    if (reset) begin
      hz.o_PC_Write    = 1'b0;
      hz.o_IFID_Write  = 1'b0;
      hz.o_IFID_Flush  = 1'b1;
      hz.o_IDEX_Flush  = 1'b1;
      hz.o_EXMEM_Flush = 1'b1;
      hz.o_Pipe_Hold   = 1'b0;
    end else begin
      hz.o_PC_Write    = pc_write_s;
      hz.o_IFID_Write  = ifid_write_s;
      hz.o_IFID_Flush  = ifid_flush_s;
      hz.o_IDEX_Flush  = idex_flush_s;
      hz.o_EXMEM_Flush = exmem_flush_s;
      hz.o_Pipe_Hold   = pipe_hold_s;
    end
  end

  assign hz.o_Mem_Timeout = tmo_r;
  assign hz.o_Stall_Count = stall_cnt_r;
  assign hz.o_State       = state_r;

endmodule
